multpath_driver: RTL and testbench

Single-clock stimulus generator and result checker for the multicycle-path adder lab. It sweeps every 4-bit operand pair (A, B) exhaustively and holds each pair stable for a programmable window of fast-clock cycles. At the end of each window it samples the adder's 5-bit sum and compares it against the expected A+B. It sits opposite the adder under test: its A/B outputs feed the adder's launch registers, and the adder's sum output returns to its sum_in.

---
 rtl/multpath_pkg.sv | 22 ++
 rtl/multpath_driver_if.sv | 42 ++++
 rtl/multpath_checker.sv | 62 ++++++
 rtl/multpath_driver.sv | 99 +++++++++
 tb/tb_multpath_driver.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/multpath_pkg.sv
// rtl/multpath_pkg.sv - shared widths, state encoding and expected-sum helper for the multicycle adder lab driver
package multpath_pkg;

    localparam int INPUT_WIDTH = 4;
    localparam int SUM_WIDTH   = 5;
    localparam int ERR_WIDTH   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    // Reference adder: operands zero-extended so the carry lands in the top sum bit.
    function automatic logic [SUM_WIDTH-1:0] expected_sum(
        input logic [INPUT_WIDTH-1:0] a,
        input logic [INPUT_WIDTH-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/multpath_driver_if.sv
// rtl/multpath_driver_if.sv - operand/result bundle between the sweep driver and its harness (MULTPATH_DRIVER_ERRLOG_EN adds the error log)
interface multpath_driver_if;
    import multpath_pkg::*;

    logic                   start;
    logic [SUM_WIDTH-1:0]   sum_in;
    logic [INPUT_WIDTH-1:0] A;
    logic [INPUT_WIDTH-1:0] B;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [ERR_WIDTH-1:0]   err_count;
`ifdef MULTPATH_DRIVER_ERRLOG_EN
    logic [INPUT_WIDTH-1:0] first_err_a;
    logic [INPUT_WIDTH-1:0] first_err_b;
    logic [SUM_WIDTH-1:0]   first_err_sum;
    logic                   first_err_valid;

    modport master (
        input  start, sum_in,
        output A, B, busy, done, pass, err_count,
        output first_err_a, first_err_b, first_err_sum, first_err_valid
    );

    modport slave (
        output start, sum_in,
        input  A, B, busy, done, pass, err_count,
        input  first_err_a, first_err_b, first_err_sum, first_err_valid
    );
`else
    modport master (
        input  start, sum_in,
        output A, B, busy, done, pass, err_count
    );

    modport slave (
        output start, sum_in,
        input  A, B, busy, done, pass, err_count
    );
`endif

endinterface

// File: rtl/multpath_checker.sv
// rtl/multpath_checker.sv - compares returned sums against A+B on compare strobes; MULTPATH_DRIVER_ERRLOG_EN adds the first-error log
module multpath_checker
    import multpath_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   cmp_stb,
    input  logic [INPUT_WIDTH-1:0] a,
    input  logic [INPUT_WIDTH-1:0] b,
    input  logic [SUM_WIDTH-1:0]   sum_in,
`ifdef MULTPATH_DRIVER_ERRLOG_EN
    output logic [INPUT_WIDTH-1:0] first_err_a,
    output logic [INPUT_WIDTH-1:0] first_err_b,
    output logic [SUM_WIDTH-1:0]   first_err_sum,
    output logic                   first_err_valid,
`endif
    output logic [ERR_WIDTH-1:0]   err_count
);

    logic                 mismatch;
    logic [ERR_WIDTH-1:0] err_q;

    assign mismatch  = cmp_stb && (sum_in != expected_sum(a, b));
    assign err_count = err_q;

    // 256 pairs per sweep fit in 9 bits, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_q <= '0;
        end else if (mismatch) begin
            err_q <= err_q + 1'b1;
        end
    end

`ifdef MULTPATH_DRIVER_ERRLOG_EN
    logic [INPUT_WIDTH-1:0] log_a_q;
    logic [INPUT_WIDTH-1:0] log_b_q;
    logic [SUM_WIDTH-1:0]   log_sum_q;
    logic                   log_valid_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            log_a_q     <= '0;
            log_b_q     <= '0;
            log_sum_q   <= '0;
            log_valid_q <= 1'b0;
        end else if (mismatch && !log_valid_q) begin
            log_a_q     <= a;
            log_b_q     <= b;
            log_sum_q   <= sum_in;
            log_valid_q <= 1'b1;
        end
    end

    assign first_err_a     = log_a_q;
    assign first_err_b     = log_b_q;
    assign first_err_sum   = log_sum_q;
    assign first_err_valid = log_valid_q;
`endif

endmodule

// File: rtl/multpath_driver.sv
// rtl/multpath_driver.sv - exhaustive 4-bit operand sweep with a HOLD-cycle multicycle window per pair (MULTPATH_DRIVER_ERRLOG_EN adds the error log)
module multpath_driver #(
    parameter int HOLD = 4
) (
    input  logic                clock_666,
    input  logic                reset,
    multpath_driver_if.master   bus
);

    localparam int IW = multpath_pkg::INPUT_WIDTH;
    localparam int EW = multpath_pkg::ERR_WIDTH;

    // The package state names are re-exposed as plain constants; HOLD is also the window parameter.
    localparam logic [1:0] ST_IDLE = multpath_pkg::IDLE;
    localparam logic [1:0] ST_HOLD = multpath_pkg::HOLD;
    localparam logic [1:0] ST_DONE = multpath_pkg::DONE;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    logic [1:0]    state;
    logic [3:0]    hold_cnt;
    logic [IW-1:0] a_q;
    logic [IW-1:0] b_q;
    logic          cmp_edge;
    logic          last_pair;
    logic          sweep_start;
    logic [EW-1:0] err_count;

    assign cmp_edge    = (state == ST_HOLD) && (hold_cnt == HOLD_LAST);
    assign last_pair   = (a_q == '1) && (b_q == '1);
    assign sweep_start = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;

    always_ff @(posedge clock_666) begin
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                        a_q      <= '0;
                        b_q      <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!cmp_edge) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end else begin
                        hold_cnt <= '0;
                        // The final pair stays on the bus after the sweep ends.
                        if (last_pair) begin
                            state <= ST_DONE;
                        end else begin
                            b_q <= b_q + 1'b1;
                            if (b_q == '1) begin
                                a_q <= a_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    a_q      <= '0;
                    b_q      <= '0;
                end
            endcase
        end
    end

    multpath_checker u_checker (
        .clk             (clock_666),
        .reset           (reset),
        .clear           (sweep_start),
        .cmp_stb         (cmp_edge),
        .a               (a_q),
        .b               (b_q),
        .sum_in          (bus.sum_in),
`ifdef MULTPATH_DRIVER_ERRLOG_EN
        .first_err_a     (bus.first_err_a),
        .first_err_b     (bus.first_err_b),
        .first_err_sum   (bus.first_err_sum),
        .first_err_valid (bus.first_err_valid),
`endif
        .err_count       (err_count)
    );

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.busy      = (state == ST_HOLD);
    assign bus.done      = (state == ST_DONE);
    assign bus.pass      = (state == ST_DONE) && (err_count == '0);
    assign bus.err_count = err_count;

endmodule

// File: tb/tb_multpath_driver.sv
// tb/tb_multpath_driver.sv - table-driven sweeps plus reset/start corner sequences for multpath_driver (honours MULTPATH_DRIVER_ERRLOG_EN)
module tb_multpath_driver;

    logic clk;
    logic rst4;
    logic rst2;
    bit   fault;

    int n_checks = 0;
    int n_fail   = 0;

    multpath_driver_if if4 ();
    multpath_driver_if if2 ();

    multpath_driver #(.HOLD(4)) dut4 (.clock_666(clk), .reset(rst4), .bus(if4));
    multpath_driver #(.HOLD(2)) dut2 (.clock_666(clk), .reset(rst2), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder models: two-stage capture for HOLD=4, one-stage for HOLD=2; fault clears sum bit 4.
    logic [4:0] p1_4, p2_4, p1_2;
    always @(posedge clk) begin
        p1_4 <= {1'b0, if4.A} + {1'b0, if4.B};
        p2_4 <= p1_4;
        p1_2 <= {1'b0, if2.A} + {1'b0, if2.B};
    end
    assign if4.sum_in = fault ? (p2_4 & 5'h0f) : p2_4;
    assign if2.sum_in = p1_2;

    typedef struct {
        bit sel2;
        bit fault;
        bit pulse;
        int exp_cycles;
        int exp_err;
        int exp_pass;
        int exp_fa;
        int exp_fb;
        int exp_fs;
        int exp_fv;
    } sweep_t;

    sweep_t tv[4];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) if2.start = v;
        else   if4.start = v;
    endtask

    function automatic int f_pair(input bit s);
        return s ? int'({if2.A, if2.B}) : int'({if4.A, if4.B});
    endfunction
    function automatic int f_busy(input bit s);
        return s ? int'(if2.busy) : int'(if4.busy);
    endfunction
    function automatic int f_done(input bit s);
        return s ? int'(if2.done) : int'(if4.done);
    endfunction
    function automatic int f_pass(input bit s);
        return s ? int'(if2.pass) : int'(if4.pass);
    endfunction
    function automatic int f_err(input bit s);
        return s ? int'(if2.err_count) : int'(if4.err_count);
    endfunction

    task automatic check_idle4(input string tag);
        check({tag, "_A"},    int'(if4.A), 0);
        check({tag, "_B"},    int'(if4.B), 0);
        check({tag, "_busy"}, int'(if4.busy), 0);
        check({tag, "_done"}, int'(if4.done), 0);
        check({tag, "_pass"}, int'(if4.pass), 0);
        check({tag, "_err"},  int'(if4.err_count), 0);
`ifdef MULTPATH_DRIVER_ERRLOG_EN
        check({tag, "_fvalid"}, int'(if4.first_err_valid), 0);
`endif
    endtask

    task automatic run_sweep(input int r);
        bit   s;
        int   h, cyc, runs, bad_len, bad_seq, run_len, p, prev;
        bit   have;
        s = tv[r].sel2;
        h = s ? 2 : 4;
        fault = tv[r].fault;
        cyc = 0; runs = 0; bad_len = 0; bad_seq = 0; run_len = 0; prev = 0; have = 0;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        while (1) begin
            @(negedge clk);
            if (f_done(s) != 0) break;
            if (cyc == 0) set_start(s, 1'b0);
            else if (tv[r].pulse) set_start(s, cyc[4]);
            if (f_busy(s) != 0) begin
                p = f_pair(s);
                if (!have || p != prev) begin
                    if (have && run_len != h) bad_len++;
                    if (p != (runs & 255)) bad_seq++;
                    runs++;
                    prev = p;
                    have = 1;
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end
            if (cyc >= 5000) break;
            @(posedge clk);
            cyc++;
        end
        set_start(s, 1'b0);
        if (have && run_len != h) bad_len++;
        check($sformatf("row%0d_done_cycles", r), cyc, tv[r].exp_cycles);
        check($sformatf("row%0d_done", r), f_done(s), 1);
        check($sformatf("row%0d_busy", r), f_busy(s), 0);
        check($sformatf("row%0d_err_count", r), f_err(s), tv[r].exp_err);
        check($sformatf("row%0d_pass", r), f_pass(s), tv[r].exp_pass);
        check($sformatf("row%0d_final_AB", r), f_pair(s), 8'hff);
        check($sformatf("row%0d_pair_count", r), runs, 256);
        check($sformatf("row%0d_hold_len_errors", r), bad_len, 0);
        check($sformatf("row%0d_order_errors", r), bad_seq, 0);
`ifdef MULTPATH_DRIVER_ERRLOG_EN
        if (s) begin
            check($sformatf("row%0d_fvalid", r), int'(if2.first_err_valid), tv[r].exp_fv);
        end else begin
            check($sformatf("row%0d_fvalid", r), int'(if4.first_err_valid), tv[r].exp_fv);
            if (tv[r].exp_fv != 0) begin
                check($sformatf("row%0d_fa", r), int'(if4.first_err_a), tv[r].exp_fa);
                check($sformatf("row%0d_fb", r), int'(if4.first_err_b), tv[r].exp_fb);
                check($sformatf("row%0d_fsum", r), int'(if4.first_err_sum), tv[r].exp_fs);
            end
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        //        sel2 flt pls  cycles  err pass fa fb fs fv
        tv[0] = '{1'b0, 1'b0, 1'b0, 1024,   0, 1,  0, 0, 0, 0};
        tv[1] = '{1'b1, 1'b0, 1'b0,  512,   0, 1,  0, 0, 0, 0};
        tv[2] = '{1'b0, 1'b0, 1'b1, 1024,   0, 1,  0, 0, 0, 0};
        // bit 4 only matters for sums of 16..30: 120 pairs, first is (1,15) read back as 0
        tv[3] = '{1'b0, 1'b1, 1'b0, 1024, 120, 0,  1, 15, 0, 1};

        fault = 1'b0;
        if4.start = 1'b0;
        if2.start = 1'b0;
        rst4 = 1'b1;
        rst2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        rst2 = 1'b0;
        check_idle4("reset");
        check("reset_dut2_busy", int'(if2.busy), 0);
        check("reset_dut2_err", int'(if2.err_count), 0);

        for (int r = 0; r < 4; r++) run_sweep(r);

        // start held high in DONE: new sweep begins, previous errors cleared
        @(negedge clk);
        if4.start = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("restart_busy", int'(if4.busy), 1);
        check("restart_done", int'(if4.done), 0);
        check("restart_err", int'(if4.err_count), 0);
        check("restart_pair", f_pair(1'b0), 0);
`ifdef MULTPATH_DRIVER_ERRLOG_EN
        check("restart_fvalid", int'(if4.first_err_valid), 0);
`endif
        if4.start = 1'b0;

        // reset mid-window at pair (7,3)
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (f_pair(1'b0) == 8'h73) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_pair_7_3", int'(found), 1);
        @(negedge clk);
        rst4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        check_idle4("midreset");

        fault = 1'b0;
        if4.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b0;
        check("resweep_busy", int'(if4.busy), 1);
        check("resweep_pair", f_pair(1'b0), 0);
        check("resweep_err", int'(if4.err_count), 0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("resweep_pair3", f_pair(1'b0), 8'h03);

        // reset and start together from IDLE
        rst4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_busy", int'(if4.busy), 0);
        check("rst_start_done", int'(if4.done), 0);
        rst4 = 1'b0;
        if4.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle4("rst_start_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
